// File: rtl/spi_receiver_pkg.sv
// Shared types and helpers for the SPI receive path.
//   rx_state_t : receiver FSM state encoding
//   cnt_width  : width of a bit counter that indexes 0 .. data_width-1
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // A 1-bit word would give $clog2(1) = 0, so clamp to one bit.
    function automatic int cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/spi_receiver_if.sv
// Bundle of the SPI receiver's serial lines and its word output stream.
//   slave  : the receiver (consumes SCK/CS/MOSI and ready, drives the stream)
//   master : the transmitter / downstream side
interface spi_receiver_if
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                    SCK;
    logic                    CS;
    logic                    MOSI;
    logic                    ready;
    logic                    valid;
    logic [P_DATA_WIDTH-1:0] data;
    logic                    frame_err;
    logic                    overrun;
    logic                    busy;

    modport slave (
        input  SCK, CS, MOSI, ready,
        output valid, data, frame_err, overrun, busy
    );

    modport master (
        output SCK, CS, MOSI, ready,
        input  valid, data, frame_err, overrun, busy
    );

endinterface

// File: rtl/spi_receiver_sync_ff.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads P_RST_VAL into every stage
//   d_i    : asynchronous input
//   q_o    : synchronised output (last stage)
module sync_ff
    import spi_pkg::*;
#(
    parameter int   P_DEPTH   = 2,
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [P_DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {P_DEPTH{P_RST_VAL}};
        end else begin
            sync_q <= {sync_q[P_DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[P_DEPTH-1];

endmodule

// File: rtl/spi_receiver.sv
// SPI receiver / checker for self-test of the transmit path.
// Oversamples SCK/CS/MOSI in the clk_100 domain, deserialises MSB-first
// words and offers them on a valid/ready stream; flags truncated frames
// and overruns with one-cycle pulses.
//   clk_100 : system clock
//   a_rst   : asynchronous active-low reset
//   bus     : serial lines in, word stream + status out (slave modport)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CS inactive; bit counter held at 0, SCK edges ignored
// SHIFT | CS active; each SCK rise shifts one bit, every W bits a word
module spi_receiver
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter bit P_CS_POLAR    = 1'b1,
    parameter int P_SYNC_STAGES = 2
) (
    input logic           clk_100,
    input logic           a_rst,
    spi_receiver_if.slave bus
);

    localparam int               CNT_W    = cnt_width(P_DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_WIDTH - 1);

    logic                    sck_s;
    logic                    cs_s;
    logic                    mosi_s;
    logic                    sck_prev_q;
    logic                    sck_rise;
    logic                    cs_act;

    rx_state_t               state_q;
    rx_state_t               state_d;

    logic [P_DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [P_DATA_WIDTH-1:0] data_q;
    logic                    valid_q;
    logic                    frame_err_q;
    logic                    overrun_q;

    logic                    busy;
    logic                    shift_en;
    logic                    word_done;
    logic                    trunc;
    logic                    clr_cnt;
    logic [P_DATA_WIDTH-1:0] word;

    // MOSI shares the SCK synchroniser depth so both stay cycle-aligned.
    sync_ff #(.P_DEPTH(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sync_sck (
        .clk_i (clk_100),
        .rst_ni(a_rst),
        .d_i   (bus.SCK),
        .q_o   (sck_s)
    );

    sync_ff #(.P_DEPTH(P_SYNC_STAGES), .P_RST_VAL(~P_CS_POLAR)) u_sync_cs (
        .clk_i (clk_100),
        .rst_ni(a_rst),
        .d_i   (bus.CS),
        .q_o   (cs_s)
    );

    sync_ff #(.P_DEPTH(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk_100),
        .rst_ni(a_rst),
        .d_i   (bus.MOSI),
        .q_o   (mosi_s)
    );

    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_act   = (cs_s == P_CS_POLAR);
    assign word     = {shreg_q[P_DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_act)  state_d = SHIFT;
            SHIFT:   if (!cs_act) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CS deselect outranks a coincident SCK rise, so every shift/complete
    // term is qualified with cs_act.
    always_comb begin
        busy      = (state_q == SHIFT);
        shift_en  = busy && cs_act && sck_rise;
        word_done = shift_en && (bit_cnt_q == LAST_BIT);
        trunc     = busy && !cs_act && (bit_cnt_q != '0);
        clr_cnt   = !busy || !cs_act;
    end

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            sck_prev_q  <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sck_prev_q  <= sck_s;
            frame_err_q <= trunc;
            overrun_q   <= word_done && valid_q && !bus.ready;

            if (clr_cnt) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
            end

            if (trunc) begin
                shreg_q <= '0;
            end else if (shift_en) begin
                shreg_q <= word;
            end

            // A handshake in the completion cycle frees the register for
            // the new word, so no overrun is flagged in that case.
            if (word_done && (!valid_q || bus.ready)) begin
                data_q  <= word;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.valid     = valid_q;
    assign bus.data      = data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_receiver.sv
module tb_spi_receiver;

    localparam int W  = 8;
    localparam int HP = 8;

    logic clk;
    logic rst_n;
    logic sck;
    logic cs_sel;
    logic mosi;
    logic ready;

    int checks;
    int errors;

    spi_receiver_if #(.P_DATA_WIDTH(W)) if1 ();
    spi_receiver_if #(.P_DATA_WIDTH(W)) if0 ();

    assign if1.SCK   = sck;
    assign if1.CS    = cs_sel;
    assign if1.MOSI  = mosi;
    assign if1.ready = ready;
    assign if0.SCK   = sck;
    assign if0.CS    = ~cs_sel;
    assign if0.MOSI  = mosi;
    assign if0.ready = ready;

    spi_receiver #(.P_DATA_WIDTH(W), .P_CS_POLAR(1'b1), .P_SYNC_STAGES(2)) u_dut1 (
        .clk_100(clk),
        .a_rst  (rst_n),
        .bus    (if1)
    );

    spi_receiver #(.P_DATA_WIDTH(W), .P_CS_POLAR(1'b0), .P_SYNC_STAGES(2)) u_dut0 (
        .clk_100(clk),
        .a_rst  (rst_n),
        .bus    (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation counters, sampled on the falling edge.
    logic [W-1:0] hs_q1[$];
    logic [W-1:0] hs_q0[$];
    int fe1, fe0, ov1, ov0, busy_low;
    bit in_words;

    always @(negedge clk) begin
        if (if1.valid && if1.ready) hs_q1.push_back(if1.data);
        if (if0.valid && if0.ready) hs_q0.push_back(if0.data);
        if (if1.frame_err) fe1++;
        if (if0.frame_err) fe0++;
        if (if1.overrun) ov1++;
        if (if0.overrun) ov0++;
        if (in_words && (!if1.busy || !if0.busy)) busy_low++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        hs_q1.delete();
        hs_q0.delete();
        fe1 = 0; fe0 = 0; ov1 = 0; ov0 = 0; busy_low = 0;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(HP);
        sck = 1'b1;
        tick(HP);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic cs_on();
        cs_sel = 1'b1;
        tick(4);
    endtask

    task automatic cs_off();
        tick(4);
        cs_sel = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sck = 1'b0; cs_sel = 1'b0; mosi = 1'b0; ready = 1'b0;
        in_words = 1'b0;
        clear_mon();
        tick(3);
        @(negedge clk);
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if1.valid); end
        checks++; if (if1.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if1.data); end
        checks++; if (if1.frame_err !== 1'b0 || if1.overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", if1.frame_err, if1.overrun); end
        checks++; if (if1.busy !== 1'b0 || if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", if1.busy, if0.busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(4);
        checks++; if (if1.busy !== 1'b0 || if0.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy %b/%b want 0/0", if1.busy, if0.busy); end
    endtask

    task automatic test_reset_mid_frame();
        ready = 1'b1;
        clear_mon();
        cs_on();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        rst_n = 1'b0;
        cs_sel = 1'b0;
        @(negedge clk);
        checks++; if (if1.valid !== 1'b0 || if1.data !== 8'h00 || if1.frame_err !== 1'b0 || if1.overrun !== 1'b0 || if1.busy !== 1'b0)
            begin errors++; $display("FAIL midreset_outputs: got v=%b d=%h fe=%b ov=%b busy=%b want all 0", if1.valid, if1.data, if1.frame_err, if1.overrun, if1.busy); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy0: got %b want 0", if0.busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(4);
        cs_on();
        send_word(8'h3C);
        cs_off();
        checks++; if (hs_q1.size() != 1 || hs_q1[0] !== 8'h3C) begin errors++; $display("FAIL midreset_next_frame: got %0d words first=%h want 1 word 3c", hs_q1.size(), (hs_q1.size() > 0) ? hs_q1[0] : 8'hxx); end
        checks++; if (fe1 != 0) begin errors++; $display("FAIL midreset_frame_err: got %0d pulses want 0", fe1); end
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        w = 8'hA5;
        ready = 1'b1;
        clear_mon();
        cs_on();
        for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
        mosi = w[0];
        tick(HP);
        sck = 1'b1;
        @(posedge clk);                       // edge k: final SCK rise first sampled
        @(negedge clk);
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL single_lat_k: got valid %b want 0", if1.valid); end
        @(posedge clk);                       // k+1
        @(negedge clk);
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL single_lat_k1: got valid %b want 0", if1.valid); end
        @(posedge clk);                       // k+2
        @(negedge clk);
        checks++; if (if1.valid !== 1'b1 || if1.data !== 8'hA5) begin errors++; $display("FAIL single_lat_k2: got v=%b d=%h want 1 a5", if1.valid, if1.data); end
        checks++; if (if0.valid !== 1'b1 || if0.data !== 8'hA5) begin errors++; $display("FAIL single_polar0: got v=%b d=%h want 1 a5", if0.valid, if0.data); end
        @(posedge clk);                       // k+3: handshake
        @(negedge clk);
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got valid %b want 0", if1.valid); end
        @(posedge clk); #1;
        tick(HP - 4);
        sck = 1'b0;
        cs_off();
        checks++; if (hs_q1.size() != 1 || fe1 != 0 || ov1 != 0) begin errors++; $display("FAIL single_counts: got hs=%0d fe=%0d ov=%0d want 1 0 0", hs_q1.size(), fe1, ov1); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp [3];
        exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
        ready = 1'b1;
        clear_mon();
        cs_on();
        in_words = 1'b1;
        for (int i = 0; i < 3; i++) send_word(exp[i]);
        tick(4);
        in_words = 1'b0;
        cs_off();
        checks++; if (hs_q1.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", hs_q1.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < hs_q1.size()) begin
                checks++; if (hs_q1[i] !== exp[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, hs_q1[i], exp[i]); end
            end
        end
        checks++; if (hs_q0.size() != 3 || hs_q0[2] !== 8'hFF) begin errors++; $display("FAIL b2b_polar0: got %0d words want 3 ending ff", hs_q0.size()); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy: got %0d low cycles want 0", busy_low); end
        checks++; if (fe1 != 0 || fe0 != 0) begin errors++; $display("FAIL b2b_frame_err: got %0d/%0d want 0/0", fe1, fe0); end
    endtask

    task automatic test_truncated();
        ready = 1'b1;
        clear_mon();
        cs_on();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        cs_off();
        checks++; if (fe1 != 1) begin errors++; $display("FAIL trunc_frame_err: got %0d pulses want 1", fe1); end
        checks++; if (fe0 != 1) begin errors++; $display("FAIL trunc_frame_err_p0: got %0d pulses want 1", fe0); end
        checks++; if (hs_q1.size() != 0 || if1.valid !== 1'b0) begin errors++; $display("FAIL trunc_valid: got hs=%0d valid=%b want 0 0", hs_q1.size(), if1.valid); end
        cs_on();
        send_word(8'h5A);
        cs_off();
        checks++; if (hs_q1.size() != 1 || hs_q1[0] !== 8'h5A) begin errors++; $display("FAIL trunc_next_frame: got %0d words first=%h want 1 word 5a", hs_q1.size(), (hs_q1.size() > 0) ? hs_q1[0] : 8'hxx); end
        checks++; if (fe1 != 1) begin errors++; $display("FAIL trunc_frame_err_total: got %0d want 1", fe1); end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        clear_mon();
        cs_on();
        send_word(8'h11);
        send_word(8'h22);
        cs_off();
        checks++; if (if1.valid !== 1'b1 || if1.data !== 8'h11) begin errors++; $display("FAIL ovr_hold: got v=%b d=%h want 1 11", if1.valid, if1.data); end
        checks++; if (ov1 != 1 || ov0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d/%0d want 1/1", ov1, ov0); end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        checks++; if (hs_q1.size() != 1 || hs_q1[0] !== 8'h11) begin errors++; $display("FAIL ovr_drain: got %0d words first=%h want 1 word 11", hs_q1.size(), (hs_q1.size() > 0) ? hs_q1[0] : 8'hxx); end
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b want 0", if1.valid); end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] w;
        w = 8'h22;
        ready = 1'b0;
        clear_mon();
        cs_on();
        send_word(8'h11);
        for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
        mosi = w[0];
        tick(HP);
        sck = 1'b1;
        @(posedge clk);                       // k
        @(posedge clk); #1;                   // k+1: completion visible now
        ready = 1'b1;
        @(posedge clk); #1;                   // k+2: load and handshake together
        ready = 1'b0;
        @(negedge clk);
        checks++; if (if1.valid !== 1'b1 || if1.data !== 8'h22) begin errors++; $display("FAIL simul_p1: got v=%b d=%h want 1 22", if1.valid, if1.data); end
        checks++; if (if0.valid !== 1'b1 || if0.data !== 8'h22) begin errors++; $display("FAIL simul_p0: got v=%b d=%h want 1 22", if0.valid, if0.data); end
        @(posedge clk); #1;
        tick(HP - 4);
        sck = 1'b0;
        cs_off();
        checks++; if (ov1 != 0 || ov0 != 0) begin errors++; $display("FAIL simul_overrun: got %0d/%0d want 0/0", ov1, ov0); end
        checks++; if (hs_q1.size() != 1 || hs_q1[0] !== 8'h11 || hs_q0.size() != 1) begin errors++; $display("FAIL simul_handshake: got %0d/%0d words want 1/1 of 11", hs_q1.size(), hs_q0.size()); end
        ready = 1'b1;
        tick(2);
        checks++; if (hs_q1.size() != 2 || hs_q1[1] !== 8'h22 || if1.valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %0d words valid=%b want 2 words ending 22, valid 0", hs_q1.size(), if1.valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_frame();
        test_single();
        test_back_to_back();
        test_truncated();
        test_overrun();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
- Receiver/checker that sits directly downstream of the SPI transmitter; consumes its SCK/CS/MOSI lines (loopback or on a second board).
- Oversamples the three lines in the clk_100 domain, deserialises MSB-first words, and presents them on a valid/ready output port.
- Flags two error conditions: truncated frames and overrun. Used for self-test of the transmit path.

Parameters:
P_DATA_WIDTH, 8, bits per word; must match the transmitter.
P_CS_POLAR, 1, CS level meaning "selected" (1 = active-high, 0 = active-low).
P_SYNC_STAGES, 2, synchroniser flops per input line; minimum 2.

Ports:
clk_100  input  1  system clock, 100 MHz.
a_rst  input  1  asynchronous reset, active-low; one clock, no other reset.
SCK  input  1  serial clock from the transmitter (single-ended, positive-polarity leg).
CS  input  1  chip select; active level is P_CS_POLAR.
MOSI  input  1  serial data; sampled on SCK rising edge.
ready  input  1  downstream accepts data when valid && ready.
valid  output  1  data holds a completed word.
data  output  P_DATA_WIDTH  received word, MSB = first bit on the wire.
frame_err  output  1  one-cycle pulse: CS deasserted with a partial word.
overrun  output  1  one-cycle pulse: word completed while the output was still full.
busy  output  1  high while in state SHIFT.

Behaviour:
- Reset (a_rst = 0, asynchronous):
  - valid = 0, data = 0, frame_err = 0, overrun = 0, busy = 0.
  - Shift register and bit counter cleared; synchroniser flops set to the idle levels: SCK = 0, CS = !P_CS_POLAR, MOSI = 0.
  - State = IDLE.
- Synchronisation:
  - Each input passes through P_SYNC_STAGES flops.
  - sck_prev is a register of synchronised SCK; sck_rise = sck_s && !sck_prev.
  - MOSI uses the same synchroniser depth, so it stays aligned with SCK.
  - cs_act = (cs_s == P_CS_POLAR).
- Input timing requirement: SCK high and low phases ≥ P_SYNC_STAGES+1 clk_100 cycles each; MOSI stable from 1 cycle before to 1 cycle after the SCK rising edge.
- FSM, states IDLE and SHIFT (enum in package):
  - IDLE: bit_cnt = 0; sck_rise ignored. cs_act → SHIFT.
  - SHIFT, on sck_rise: shreg <= {shreg[W-2:0], mosi_s}; bit_cnt++.
  - SHIFT, word complete (sck_rise with bit_cnt == W-1):
    - The completed word {shreg[W-2:0], mosi_s} is offered to the output register in the same cycle.
    - bit_cnt <= 0; stay in SHIFT, so back-to-back words within one CS frame are supported.
  - SHIFT, !cs_act:
    - bit_cnt != 0: frame_err pulses 1 cycle, partial bits are discarded, → IDLE.
    - bit_cnt == 0: → IDLE silently.
  - !cs_act has priority over a simultaneous sck_rise.
- Output register:
  - Loaded when a word completes and (!valid || ready); valid <= 1.
  - Handshake on valid && ready with no completion in that cycle: valid <= 0; data holds its last value.
  - Completion in the same cycle as a handshake: the new word loads, valid stays 1, no overrun.
  - Completion while valid && !ready: the new word is dropped, the old word is kept, overrun pulses 1 cycle.
  - Frame boundaries do not alter valid or data.
- Latency: the SCK rising edge that carries the final bit is first sampled high at clk_100 edge k. With P_SYNC_STAGES = 2, valid is high after edge k+2.
- bit_cnt width is $clog2(P_DATA_WIDTH); no wrap beyond W-1.

Decomposition:
- Package spi_pkg: typedef enum logic [0:0] {IDLE, SHIFT} rx_state_t; localparam helper for counter width.
- Sub-module sync_ff: parameterised depth and reset value, one bit wide, async active-low reset; instantiated three times.
- Everything else stays in one always_ff block plus a small combinational next-state block.

Test Plan:
- Reset mid-frame: drive 5 bits, pull a_rst low for 1 cycle → all outputs 0, state IDLE. A following complete frame 0x3C is received correctly.
- Single word: CS active, send 0xA5 MSB-first with SCK half-period 8 cycles, ready = 1 → valid pulses 1 cycle, data = 0xA5, no error pulses, valid high 2 cycles after the last SCK rise is sampled.
- Back-to-back: one CS frame carrying 0x01, 0x80, 0xFF with ready = 1 → three handshakes in order with exactly those values, busy high throughout, frame_err never pulses.
- Truncated frame: send 3 bits (1,0,1) then deassert CS → frame_err pulses exactly once, valid stays 0; the next full frame 0x5A is received as 0x5A.
- Overrun: ready = 0, send 0x11 then 0x22 → valid = 1, data = 0x11, overrun pulses once at the second completion. Raising ready then yields one handshake with 0x11.
- Simultaneous handshake and completion: holding 0x11, assert ready in the exact cycle 0x22 completes → data = 0x22, valid stays 1, overrun = 0. Repeat with P_CS_POLAR = 0 → same results.
